// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core MEM stage
// and a DMA/loader port; one doubleword access per grant with fixed 2-cycle response.
module dmem_access_arbiter #(
    parameter logic [63:0] MEM_LIMIT   = 64'd297,
    parameter bit          ALIGN_CHECK = 1'b1,
    localparam int unsigned DW         = 64
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [DW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_err,
    output logic          core_stall,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [DW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_err,
    output logic          dma_stall,

    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, last_owner_q;
    logic          we_q, err_q;
    logic [DW-1:0] addr_q, wdata_q, rdata_q;

    logic          grant_core, grant_dma;
    logic          sel_we, sel_err;
    logic [DW-1:0] sel_addr, sel_wdata;

    // Next state and grant decision; both requesting goes to whoever did not own last
    always_comb begin
        state_d    = state_q;
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_req && (!dma_req || last_owner_q == OWN_DMA)) begin
                    grant_core = 1'b1;
                    state_d    = ACCESS;
                end else if (dma_req) begin
                    grant_dma  = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request mux and range/alignment check on the granted request
    always_comb begin
        sel_we    = grant_dma ? dma_we    : core_we;
        sel_addr  = grant_dma ? dma_addr  : core_addr;
        sel_wdata = grant_dma ? dma_wdata : core_wdata;
        sel_err   = (sel_addr > MEM_LIMIT) || (ALIGN_CHECK && (sel_addr[2:0] != 3'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CORE;
            last_owner_q <= OWN_DMA;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_core || grant_dma) begin
                owner_q <= grant_dma ? OWN_DMA : OWN_CORE;
                we_q    <= sel_we;
                err_q   <= sel_err;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (we_q || err_q) ? '0 : mem_rdata;
            end
            if (state_q == RESP) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // Memory strobes only in ACCESS; reset blocks a write on the edge it is sampled
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = (state_q == ACCESS) && !we_q && !err_q;
        mem_write = (state_q == ACCESS) && we_q && !err_q && !reset;
    end

    always_comb begin
        core_gnt    = grant_core && !reset;
        dma_gnt     = grant_dma && !reset;
        core_rvalid = (state_q == RESP) && (owner_q == OWN_CORE);
        dma_rvalid  = (state_q == RESP) && (owner_q == OWN_DMA);
        core_rdata  = core_rvalid ? rdata_q : '0;
        dma_rdata   = dma_rvalid  ? rdata_q : '0;
        core_err    = core_rvalid && err_q;
        dma_err     = dma_rvalid  && err_q;
        core_stall  = core_req && !core_rvalid;
        dma_stall   = dma_req  && !dma_rvalid;
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: byte-array data memory, a transaction-slot model checked
// every cycle, and directed transactions with hand-computed results.
module tb_dmem_access_arbiter;

    localparam logic [63:0] LIMIT = 64'd297;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [63:0] core_addr = '0, core_wdata = '0;
    logic        core_gnt, core_rvalid, core_err, core_stall;
    logic [63:0] core_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [63:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt, dma_rvalid, dma_err, dma_stall;
    logic [63:0] dma_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    dmem_access_arbiter #(.MEM_LIMIT(LIMIT), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_err(core_err), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_err(dma_err), .dma_stall(dma_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Byte-addressed data memory, bytes 0..304, little-endian doublewords
    logic [7:0] mem [0:304] = '{default: 8'h00};

    always_comb begin
        mem_rdata = '0;
        if (mem_read && mem_addr <= LIMIT)
            for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr[8:0]) + i];
    end

    always @(posedge clk) begin
        if (mem_write && mem_addr <= LIMIT)
            for (int i = 0; i < 8; i++) mem[int'(mem_addr[8:0]) + i] <= mem_wdata[8*i +: 8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Model: a granted transaction occupies three cycle slots (grant, memory op, response)
    int          free_at = 0, acc_at = -1, resp_at = -1;
    bit          m_last = 1'b1;
    bit          m_owner, m_we, m_err;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [63:0] shadow [logic [63:0]];

    always @(negedge clk) begin
        logic        e_cg, e_dg, e_rd, e_wr, e_cv, e_dv, e_ce, e_de;
        logic [63:0] e_crd, e_drd;
        {e_cg, e_dg, e_rd, e_wr, e_cv, e_dv, e_ce, e_de} = '0;
        e_crd = '0;
        e_drd = '0;
        if (reset) begin
            chk("mem_write_in_reset", 64'(mem_write), 64'd0);
            acc_at  = -1;
            resp_at = -1;
            free_at = edge_cnt + 1;
            m_last  = 1'b1;
        end else begin
            if (edge_cnt == free_at) begin
                if (core_req || dma_req) begin
                    m_owner = (core_req && dma_req) ? !m_last : dma_req;
                    m_we    = m_owner ? dma_we    : core_we;
                    m_addr  = m_owner ? dma_addr  : core_addr;
                    m_wdata = m_owner ? dma_wdata : core_wdata;
                    m_err   = (m_addr > LIMIT) || (m_addr % 64'd8 != 64'd0);
                    e_cg    = !m_owner;
                    e_dg    = m_owner;
                    acc_at  = edge_cnt + 1;
                    resp_at = edge_cnt + 2;
                    free_at = edge_cnt + 3;
                end else begin
                    free_at = edge_cnt + 1;
                end
            end
            if (edge_cnt == acc_at) begin
                e_rd = !m_we && !m_err;
                e_wr = m_we && !m_err;
                chk("mem_addr", mem_addr, m_addr);
                if (e_wr) begin
                    chk("mem_wdata", mem_wdata, m_wdata);
                    shadow[m_addr] = m_wdata;
                end
                m_rdata = (e_rd && shadow.exists(m_addr)) ? shadow[m_addr] : 64'd0;
            end
            if (edge_cnt == resp_at) begin
                e_cv   = !m_owner;
                e_dv   = m_owner;
                e_crd  = m_owner ? 64'd0 : m_rdata;
                e_drd  = m_owner ? m_rdata : 64'd0;
                e_ce   = !m_owner && m_err;
                e_de   = m_owner && m_err;
                m_last = m_owner;
            end
            chk("core_gnt",    64'(core_gnt),    64'(e_cg));
            chk("dma_gnt",     64'(dma_gnt),     64'(e_dg));
            chk("mem_read",    64'(mem_read),    64'(e_rd));
            chk("mem_write",   64'(mem_write),   64'(e_wr));
            chk("core_rvalid", 64'(core_rvalid), 64'(e_cv));
            chk("dma_rvalid",  64'(dma_rvalid),  64'(e_dv));
            chk("core_rdata",  core_rdata,       e_crd);
            chk("dma_rdata",   dma_rdata,        e_drd);
            chk("core_err",    64'(core_err),    64'(e_ce));
            chk("dma_err",     64'(dma_err),     64'(e_de));
            chk("core_stall",  64'(core_stall),  64'(core_req && !e_cv));
            chk("dma_stall",   64'(dma_stall),   64'(dma_req && !e_dv));
        end
    end

    // One request held until its response; lat = cycles from request to rvalid
    task automatic txn(input bit port, input logic we, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er, output int lat);
        int start;
        bit seen;
        start = edge_cnt;
        seen  = 1'b0;
        rd    = '0;
        er    = 1'b0;
        lat   = -1;
        if (port) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk); #1;
            if (port ? dma_rvalid : core_rvalid) begin
                seen = 1'b1;
                rd   = port ? dma_rdata : core_rdata;
                er   = port ? dma_err : core_err;
                lat  = edge_cnt - start;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: port %0d addr %h got no rvalid, required within 12 cycles", port, a);
        end
        @(posedge clk); #1;
        if (port) begin
            dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        end else begin
            core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, rd2;
        logic        er, er2;
        int          lat, lat2;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mem_addr",    mem_addr,            64'd0);
        chk("rst_mem_wdata",   mem_wdata,           64'd0);
        chk("rst_core_rvalid", 64'(core_rvalid),    64'd0);
        chk("rst_dma_rdata",   dma_rdata,           64'd0);
        chk("rst_mem_strobes", 64'({mem_read, mem_write}), 64'd0);

        // 1: core write @256
        txn(1'b0, 1'b1, 64'd256, 64'h1122334455667788, rd, er, lat);
        chk("t1_latency", 64'(lat), 64'd2);
        chk("t1_err", 64'(er), 64'd0);
        chk("t1_mem_byte256", 64'(mem[256]), 64'h88);
        chk("t1_mem_byte263", 64'(mem[263]), 64'h11);

        // 2: core read back @256
        txn(1'b0, 1'b0, 64'd256, 64'd0, rd, er, lat);
        chk("t2_rdata", rd, 64'h1122334455667788);
        chk("t2_latency", 64'(lat), 64'd2);

        // 3: both request after reset -> core first; then after a core-only access -> dma first
        do_reset();
        fork
            txn(1'b0, 1'b0, 64'd256, 64'd0, rd, er, lat);
            txn(1'b1, 1'b1, 64'd272, 64'hAAAABBBBCCCCDDDD, rd2, er2, lat2);
        join
        chk("t3_core_first_lat", 64'(lat), 64'd2);
        chk("t3_dma_second_lat", 64'(lat2), 64'd5);
        chk("t3_core_rdata", rd, 64'h1122334455667788);
        txn(1'b0, 1'b0, 64'd272, 64'd0, rd, er, lat);
        chk("t3_read272", rd, 64'hAAAABBBBCCCCDDDD);
        fork
            txn(1'b0, 1'b0, 64'd272, 64'd0, rd, er, lat);
            txn(1'b1, 1'b0, 64'd256, 64'd0, rd2, er2, lat2);
        join
        chk("t3b_dma_first_lat", 64'(lat2), 64'd2);
        chk("t3b_core_second_lat", 64'(lat), 64'd5);
        chk("t3b_dma_rdata", rd2, 64'h1122334455667788);

        // 4: DMA read out of range
        txn(1'b1, 1'b0, 64'd300, 64'd0, rd, er, lat);
        chk("t4_err", 64'(er), 64'd1);
        chk("t4_rdata", rd, 64'd0);
        chk("t4_latency", 64'(lat), 64'd2);

        // 5: misaligned core write leaves memory untouched
        txn(1'b0, 1'b1, 64'h101, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        chk("t5_err", 64'(er), 64'd1);
        chk("t5_mem_byte257", 64'(mem[257]), 64'h77);
        txn(1'b0, 1'b0, 64'd256, 64'd0, rd, er, lat);
        chk("t5_readback", rd, 64'h1122334455667788);

        // Boundaries: top legal doubleword, just past it, and a wrap-around candidate
        txn(1'b1, 1'b1, 64'd296, 64'h0102030405060708, rd, er, lat);
        chk("b_top_write_err", 64'(er), 64'd0);
        chk("b_mem_byte303", 64'(mem[303]), 64'h01);
        txn(1'b0, 1'b0, 64'd296, 64'd0, rd, er, lat);
        chk("b_top_read", rd, 64'h0102030405060708);
        txn(1'b0, 1'b0, 64'd304, 64'd0, rd, er, lat);
        chk("b_304_err", 64'(er), 64'd1);
        txn(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, rd, er, lat);
        chk("b_huge_err", 64'(er), 64'd1);
        chk("b_huge_rdata", rd, 64'd0);

        // 6: reset while the write to 264 is in ACCESS
        core_req = 1'b1; core_we = 1'b1; core_addr = 64'd264; core_wdata = 64'hDEADBEEFCAFEF00D;
        #1 chk("t6_gnt", 64'(core_gnt), 64'd1);
        @(posedge clk); #1;
        chk("t6_access_write", 64'(mem_write), 64'd1);
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        #1 chk("t6_write_blocked", 64'(mem_write), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_rvalid", 64'(core_rvalid), 64'd0);
            @(posedge clk); #1;
        end
        chk("t6_mem_byte264", 64'(mem[264]), 64'h00);
        txn(1'b0, 1'b0, 64'd264, 64'd0, rd, er, lat);
        chk("t6_read264", rd, 64'd0);
        chk("t6_read_err", 64'(er), 64'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
